// File: rtl/f_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : f_deframer_pkg
// Description : Shared types and helpers for the F-stream deframer.
// Revision    : 1.0 - initial release
// ============================================================================
package f_deframer_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } deframer_state_t;

  // Saturating increment used by the fill and run-length counters.
  function automatic int unsigned sat_inc(input int unsigned value,
                                          input int unsigned max_val);
    if (value >= max_val) begin
      return max_val;
    end
    return value + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/f_stream_deframer_run_len_counter.sv
`default_nettype none
// ============================================================================
// Module      : run_len_counter
// Description : Tracks how many consecutive equal samples of F have been seen.
//               run_cnt is the registered run length (0 only before the first
//               sample after reset); run_hit flags a sample edge that extends
//               the current run.
// Revision    : 1.0 - initial release
// ============================================================================
module run_len_counter
  import f_deframer_pkg::*;
#(
  parameter int  MAX_RUN = 6,
  localparam int RUN_W   = $clog2(MAX_RUN + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             F,
  output logic [RUN_W-1:0] run_cnt,
  output logic             run_hit
);

  logic             last_bit_q, last_bit_d;
  logic [RUN_W-1:0] run_cnt_q,  run_cnt_d;
  logic             w_extends;

  // A count of zero marks "no sample yet", so the first sample always loads 1.
  assign w_extends = en && (run_cnt_q != '0) && (F == last_bit_q);

  // Next-state: remember the sample and extend or restart the run.
  always_comb begin
    last_bit_d = last_bit_q;
    run_cnt_d  = run_cnt_q;
    if (en) begin
      last_bit_d = F;
      if (w_extends) begin
        run_cnt_d = RUN_W'(sat_inc(32'(run_cnt_q), MAX_RUN));
      end else begin
        run_cnt_d = RUN_W'(1);
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_bit_q <= 1'b0;
      run_cnt_q  <= '0;
    end else begin
      last_bit_q <= last_bit_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  assign run_cnt = run_cnt_q;
  assign run_hit = w_extends;

endmodule
`default_nettype wire

// File: rtl/f_stream_deframer.sv
`default_nettype none
// ============================================================================
// Module      : f_stream_deframer
// Description : Hunts for SYNC_WORD in the serial F stream, then assembles
//               back-to-back WIDTH-bit words (first sample in the MSB). Lock
//               is dropped when F stays constant for MAX_RUN samples.
// Revision    : 1.0 - initial release
// ============================================================================
module f_stream_deframer
  import f_deframer_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5,
  parameter int               MAX_RUN   = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             F,
  input  logic             en,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             locked,
  output logic             sync_found,
  output logic             lock_lost
);

  localparam int               CNT_W      = $clog2(WIDTH + 1);
  localparam int               RUN_W      = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);
  localparam logic [RUN_W-1:0] c_run_pre  = RUN_W'(MAX_RUN - 1);

  deframer_state_t  state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [WIDTH-1:0] word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             locked_q, locked_d;
  logic             sync_found_q, sync_found_d;
  logic             lock_lost_q, lock_lost_d;

  logic [WIDTH-1:0] w_shift;
  logic [RUN_W-1:0] w_run_cnt;
  logic             w_run_ext;
  logic             w_run_max;

  run_len_counter #(
    .MAX_RUN (MAX_RUN)
  ) u_run_len (
    .CLK     (CLK),
    .RST     (RST),
    .en      (en),
    .F       (F),
    .run_cnt (w_run_cnt),
    .run_hit (w_run_ext)
  );

  assign w_shift   = {shreg_q[WIDTH-2:0], F};
  // The run reaches MAX_RUN on this edge when it is extended from MAX_RUN-1
  // or already sits saturated at MAX_RUN.
  assign w_run_max = w_run_ext && (w_run_cnt >= c_run_pre);

  // Next-state and output decode; everything holds on non-sample edges.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    fill_d       = fill_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    sync_found_d = 1'b0;
    lock_lost_d  = 1'b0;
    if (en) begin
      shreg_d = w_shift;
      case (state_q)
        HUNT: begin
          fill_d = CNT_W'(sat_inc(32'(fill_q), WIDTH));
          // fill guards against stale shreg bits left over from a lost lock.
          if ((fill_q >= c_last_idx) && (w_shift == SYNC_WORD)) begin
            state_d      = LOCKED;
            sync_found_d = 1'b1;
            bit_cnt_d    = '0;
          end
        end
        LOCKED: begin
          if (w_run_max) begin
            // Lock loss beats word completion: the partial word is dropped.
            state_d     = HUNT;
            lock_lost_d = 1'b1;
            bit_cnt_d   = '0;
            fill_d      = '0;
          end else if (bit_cnt_q == c_last_idx) begin
            word_out_d   = w_shift;
            word_valid_d = 1'b1;
            bit_cnt_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= HUNT;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      fill_q       <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_found_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      fill_q       <= fill_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      locked_q     <= locked_d;
      sync_found_q <= sync_found_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
  assign sync_found = sync_found_q;
  assign lock_lost  = lock_lost_q;

endmodule
`default_nettype wire
